// File: rtl/snd_mailbox_if.sv
// Main-CPU / sound-CPU side signals of the sound command mailbox.
// The master modport is the CPU side; the slave modport is the mailbox.
interface snd_mailbox_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             m_wr;
    logic [WIDTH-1:0] m_din;
    logic             m_rd;
    logic [WIDTH-1:0] m_dout;
    logic             reply_valid;
    logic             s_rd;
    logic [WIDTH-1:0] s_dout;
    logic             s_wr;
    logic [WIDTH-1:0] s_din;
    logic             s_inta;
    logic             s_nmi;
    logic [CW-1:0]    count;
    logic             full;
    logic             overflow;
    logic             ovf_clr;

    modport master (
        output m_wr, m_din, m_rd, s_rd, s_wr, s_din, s_inta, ovf_clr,
        input  m_dout, reply_valid, s_dout, s_nmi, count, full, overflow
    );

    modport slave (
        input  m_wr, m_din, m_rd, s_rd, s_wr, s_din, s_inta, ovf_clr,
        output m_dout, reply_valid, s_dout, s_nmi, count, full, overflow
    );
endinterface

// File: rtl/snd_mailbox.sv
// Main-to-sound command FIFO with per-command NMI and a reply latch back to main.
// s_dout behaves as a latch: it keeps the last command once the FIFO drains.
module snd_mailbox #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter bit OVERWRITE   = 1'b0,
    parameter bit CHANGE_ONLY = 1'b0
) (
    input logic          clk_sys,
    input logic          reset_n,
    snd_mailbox_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] s_dout_q, s_dout_d;
    logic [WIDTH-1:0] m_dout_q, m_dout_d;
    logic             reply_valid_q, reply_valid_d;
    logic             s_nmi_q, s_nmi_d;
    logic             overflow_q, overflow_d;
    logic             full_q, full_d;

    logic             is_empty, is_full, want, pop, push, evict, ovf_evt;
    logic [WIDTH-1:0] head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (DEPTH == 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        is_empty = (count_q == '0);
        is_full  = (count_q == FULL_CNT);
        want     = bus.m_wr && (!CHANGE_ONLY || (bus.m_din != last_q));
        pop      = bus.s_rd && !is_empty;
        // A same-cycle pop frees a slot, so a push at full is never an overflow then.
        push     = want && (!is_full || pop || OVERWRITE);
        evict    = want && is_full && !pop && OVERWRITE;
        ovf_evt  = want && is_full && !pop;

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = (pop || evict) ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop && !evict)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;

        // The new head may be the slot written this very cycle.
        head     = (push && (rd_ptr_d == wr_ptr_q)) ? bus.m_din : mem_q[rd_ptr_d];
        s_dout_d = (count_d != '0) ? head : s_dout_q;
        last_d   = push ? bus.m_din : last_q;
        full_d   = (count_d == FULL_CNT);

        s_nmi_d = s_nmi_q;
        if (push || (pop && (count_d != '0)))
            s_nmi_d = 1'b1;
        else if (bus.s_inta)
            s_nmi_d = 1'b0;

        overflow_d = overflow_q;
        if (ovf_evt)
            overflow_d = 1'b1;
        else if (bus.ovf_clr)
            overflow_d = 1'b0;

        m_dout_d      = bus.s_wr ? bus.s_din : m_dout_q;
        reply_valid_d = reply_valid_q;
        if (bus.s_wr)
            reply_valid_d = 1'b1;
        else if (bus.m_rd)
            reply_valid_d = 1'b0;
    end

    always_ff @(posedge clk_sys) begin
        if (push)
            mem_q[wr_ptr_q] <= bus.m_din;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            last_q        <= '0;
            s_dout_q      <= '0;
            m_dout_q      <= '0;
            reply_valid_q <= 1'b0;
            s_nmi_q       <= 1'b0;
            overflow_q    <= 1'b0;
            full_q        <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            last_q        <= last_d;
            s_dout_q      <= s_dout_d;
            m_dout_q      <= m_dout_d;
            reply_valid_q <= reply_valid_d;
            s_nmi_q       <= s_nmi_d;
            overflow_q    <= overflow_d;
            full_q        <= full_d;
        end
    end

    assign bus.count       = count_q;
    assign bus.full        = full_q;
    assign bus.s_dout      = s_dout_q;
    assign bus.s_nmi       = s_nmi_q;
    assign bus.overflow    = overflow_q;
    assign bus.m_dout      = m_dout_q;
    assign bus.reply_valid = reply_valid_q;
endmodule

// File: tb/tb_snd_mailbox.sv
// Bench for snd_mailbox: three configurations (plain, OVERWRITE, CHANGE_ONLY) share one stimulus.
// Directed table, hand sequences, then random traffic against a queue-style reference model.
module tb_snd_mailbox;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 3;
    localparam int NC = 3;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic         m_wr, m_rd, s_rd, s_wr, s_inta, ovf_clr;
    logic [W-1:0] m_din, s_din;

    logic [W-1:0]  o_mdout [NC];
    logic [W-1:0]  o_sdout [NC];
    logic [CW-1:0] o_cnt   [NC];
    logic          o_rv    [NC];
    logic          o_nmi   [NC];
    logic          o_full  [NC];
    logic          o_ovf   [NC];

    for (genvar g = 0; g < NC; g++) begin : g_dut
        snd_mailbox_if #(.WIDTH(W), .DEPTH(D)) bus ();
        assign bus.m_wr    = m_wr;
        assign bus.m_din   = m_din;
        assign bus.m_rd    = m_rd;
        assign bus.s_rd    = s_rd;
        assign bus.s_wr    = s_wr;
        assign bus.s_din   = s_din;
        assign bus.s_inta  = s_inta;
        assign bus.ovf_clr = ovf_clr;
        snd_mailbox #(.WIDTH(W), .DEPTH(D), .OVERWRITE(g == 1), .CHANGE_ONLY(g == 2)) dut (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .bus     (bus)
        );
        assign o_mdout[g] = bus.m_dout;
        assign o_sdout[g] = bus.s_dout;
        assign o_cnt[g]   = bus.count;
        assign o_rv[g]    = bus.reply_valid;
        assign o_nmi[g]   = bus.s_nmi;
        assign o_full[g]  = bus.full;
        assign o_ovf[g]   = bus.overflow;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cfg%0d got=%0h want=%0h at %0t", nm, c, act, exp, $time);
        end
    endtask

    // Reference model: a shift-down list of queued commands per configuration.
    logic [W-1:0] mbuf [NC][D];
    int           msz  [NC];
    logic [W-1:0] mlast[NC], msd[NC], mmd[NC];
    logic         mnmi [NC], movf[NC], mrv[NC];

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            msz[c] = 0; mlast[c] = '0; msd[c] = '0; mmd[c] = '0;
            mnmi[c] = 1'b0; movf[c] = 1'b0; mrv[c] = 1'b0;
        end
    endtask

    task automatic model_shift(input int c);
        for (int i = 0; i < D - 1; i++) mbuf[c][i] = mbuf[c][i+1];
    endtask

    task automatic model_step(input int c);
        bit popped, pushed, ev;
        popped = 1'b0; pushed = 1'b0; ev = 1'b0;
        if (s_rd && msz[c] > 0) begin
            model_shift(c);
            msz[c]--;
            popped = 1'b1;
        end
        if (m_wr && (c != 2 || m_din != mlast[c])) begin
            if (msz[c] < D) begin
                mbuf[c][msz[c]] = m_din;
                msz[c]++;
                pushed = 1'b1;
            end else if (c == 1) begin
                model_shift(c);
                mbuf[c][D-1] = m_din;
                pushed = 1'b1;
                ev = 1'b1;
            end else begin
                ev = 1'b1;
            end
        end
        if (pushed) mlast[c] = m_din;
        if (msz[c] > 0) msd[c] = mbuf[c][0];
        if (pushed || (popped && msz[c] > 0)) mnmi[c] = 1'b1;
        else if (s_inta) mnmi[c] = 1'b0;
        if (ev) movf[c] = 1'b1;
        else if (ovf_clr) movf[c] = 1'b0;
        if (s_wr) begin
            mmd[c] = s_din;
            mrv[c] = 1'b1;
        end else if (m_rd) begin
            mrv[c] = 1'b0;
        end
    endtask

    task automatic check_all(input int c);
        chk("count", c, 32'(o_cnt[c]), 32'(msz[c]));
        chk("full", c, 32'(o_full[c]), 32'(msz[c] == D));
        chk("s_dout", c, 32'(o_sdout[c]), 32'(msd[c]));
        chk("s_nmi", c, 32'(o_nmi[c]), 32'(mnmi[c]));
        chk("overflow", c, 32'(o_ovf[c]), 32'(movf[c]));
        chk("m_dout", c, 32'(o_mdout[c]), 32'(mmd[c]));
        chk("reply_valid", c, 32'(o_rv[c]), 32'(mrv[c]));
    endtask

    task automatic idle_inputs();
        m_wr = 1'b0; m_din = '0; m_rd = 1'b0; s_rd = 1'b0;
        s_wr = 1'b0; s_din = '0; s_inta = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic push(input logic [W-1:0] v);
        m_wr = 1'b1; m_din = v;
        tick();
        idle_inputs();
    endtask

    typedef struct {
        logic         wr;
        logic [W-1:0] din;
        logic         rd;
        logic         inta;
        logic         swr;
        logic [W-1:0] sdin;
        logic         mrd;
        logic [CW-1:0] cnt;
        logic [W-1:0] sd;
        logic         nmi;
        logic         rv;
        logic [W-1:0] md;
    } vec_t;

    vec_t tbl[12];
    int   nmi_sets[NC];

    initial begin
        //          wr    din    rd    inta  swr   sdin   mrd  | cnt   sd     nmi   rv    md
        tbl[0]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 8'h12, 1'b1, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 8'h12, 1'b1, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd2, 8'h12, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 8'h34, 1'b1, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h34, 1'b1, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h34, 1'b0, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h34, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{1'b1, 8'hA0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 8'hA0, 1'b1, 1'b0, 8'h00};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b0, 3'd1, 8'hA0, 1'b1, 1'b1, 8'h7E};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b1, 3'd1, 8'hA0, 1'b1, 1'b1, 8'h7F};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 8'hA0, 1'b1, 1'b0, 8'h7F};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'hA0, 1'b0, 1'b0, 8'h7F};

        // Reset state of every configuration.
        do_reset();
        for (int c = 0; c < NC; c++) check_all(c);

        // Directed table on the plain configuration.
        for (int i = 0; i < 12; i++) begin
            m_wr = tbl[i].wr; m_din = tbl[i].din; s_rd = tbl[i].rd; s_inta = tbl[i].inta;
            s_wr = tbl[i].swr; s_din = tbl[i].sdin; m_rd = tbl[i].mrd;
            tick();
            idle_inputs();
            chk($sformatf("tbl%0d.count", i), 0, 32'(o_cnt[0]), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d.s_dout", i), 0, 32'(o_sdout[0]), 32'(tbl[i].sd));
            chk($sformatf("tbl%0d.s_nmi", i), 0, 32'(o_nmi[0]), 32'(tbl[i].nmi));
            chk($sformatf("tbl%0d.reply_valid", i), 0, 32'(o_rv[0]), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d.m_dout", i), 0, 32'(o_mdout[0]), 32'(tbl[i].md));
        end

        // Overflow: push 1..5 into a depth-4 FIFO, then drain.
        do_reset();
        for (int k = 1; k <= 5; k++) push(8'(k));
        for (int c = 0; c < NC; c++) begin
            chk("ovf.count", c, 32'(o_cnt[c]), 32'd4);
            chk("ovf.full", c, 32'(o_full[c]), 32'd1);
            chk("ovf.overflow", c, 32'(o_ovf[c]), 32'd1);
        end
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < NC; c++)
                chk($sformatf("ovf.pop%0d", k), c, 32'(o_sdout[c]), (c == 1) ? 32'(k + 2) : 32'(k + 1));
            s_rd = 1'b1;
            tick();
            idle_inputs();
        end
        ovf_clr = 1'b1;
        tick();
        idle_inputs();
        for (int c = 0; c < NC; c++) begin
            chk("ovf.drained", c, 32'(o_cnt[c]), 32'd0);
            chk("ovf.cleared", c, 32'(o_ovf[c]), 32'd0);
        end

        // Change-only filtering: 0x55, 0x55, 0x66.
        do_reset();
        for (int c = 0; c < NC; c++) nmi_sets[c] = 0;
        for (int k = 0; k < 3; k++) begin
            push((k == 2) ? 8'h66 : 8'h55);
            for (int c = 0; c < NC; c++) nmi_sets[c] += int'(o_nmi[c]);
            s_inta = 1'b1;
            tick();
            idle_inputs();
        end
        for (int c = 0; c < NC; c++) begin
            chk("chg.count", c, 32'(o_cnt[c]), (c == 2) ? 32'd2 : 32'd3);
            chk("chg.nmi_sets", c, 32'(nmi_sets[c]), (c == 2) ? 32'd2 : 32'd3);
        end

        // Random traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            m_wr    = ($urandom_range(0, 1) == 1);
            m_din   = 8'($urandom_range(0, 3));
            s_rd    = ($urandom_range(0, 2) == 0);
            s_inta  = ($urandom_range(0, 3) == 0);
            s_wr    = ($urandom_range(0, 4) == 0);
            s_din   = 8'($urandom);
            m_rd    = ($urandom_range(0, 3) == 0);
            ovf_clr = ($urandom_range(0, 7) == 0);
            tick();
            for (int c = 0; c < NC; c++) begin
                model_step(c);
                check_all(c);
            end
            idle_inputs();
        end

        // Asynchronous reset between edges with commands pending.
        do_reset();
        push(8'h11);
        push(8'h22);
        s_wr = 1'b1; s_din = 8'h5A; m_wr = 1'b1; m_din = 8'h33;
        tick();
        idle_inputs();
        chk("arst.pre_count", 0, 32'(o_cnt[0]), 32'd3);
        chk("arst.pre_nmi", 0, 32'(o_nmi[0]), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        for (int c = 0; c < NC; c++) check_all(c);
        @(negedge clk_sys);
        reset_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/snd_mailbox.md
# snd_mailbox

Parametrised main-to-sound command mailbox for the arcade cores; it replaces the single-byte sound latch with change-detect NMI. The main CPU pushes commands into a DEPTH-entry FIFO. Every accepted command raises a pending NMI toward the sound CPU until that CPU acknowledges it. A reply latch with a valid flag carries status back from the sound CPU to the main CPU.

## Interface
- WIDTH, 8: command/reply data width.
- DEPTH, 4: FIFO entries; power of two, 1..256.
- OVERWRITE, 0: full-FIFO policy. 0 = drop the incoming write. 1 = discard the oldest entry and accept the new one.
- CHANGE_ONLY, 0: 1 = ignore a write equal to the last accepted command (legacy latch behaviour).
- clk_sys  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m_wr  in  1  main CPU write strobe, one clk_sys per access (caller pre-qualifies with clk_en/decode).
- m_din  in  WIDTH  command byte.
- m_rd  in  1  main CPU read strobe for reply; clears reply_valid.
- m_dout  out  WIDTH  reply latch.
- reply_valid  out  1  reply written and not yet read.
- s_rd  in  1  sound CPU read strobe; pops FIFO head.
- s_dout  out  WIDTH  registered current command.
- s_wr  in  1  sound CPU reply write strobe.
- s_din  in  WIDTH  reply byte.
- s_inta  in  1  sound CPU interrupt acknowledge (IORQ & M1).
- s_nmi  out  1  pending-command interrupt, level.
- count  out  clog2(DEPTH)+1  FIFO occupancy.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky; set when a write is dropped or an entry is overwritten.
- ovf_clr  in  1  synchronous clear of overflow.

## Operation
- Reset (async, reset_n=0): pointers, count, s_dout, m_dout, reply_valid, s_nmi, overflow, and the last-accepted register all go to 0. The memory contents are don't-care.
- Push acceptance: m_wr=1, and, when CHANGE_ONLY=1, also m_din differs from the last accepted value. The last-accepted register updates on every accepted push, including an overwrite.
- Push when not full: write to mem[wr_ptr]; wr_ptr++ (mod DEPTH); count++.
- Push when full with OVERWRITE=0: data is dropped; overflow←1; pointers and count are unchanged.
- Push when full with OVERWRITE=1: mem[wr_ptr] is written; wr_ptr++ and rd_ptr++; count stays DEPTH; overflow←1.
- Pop: s_rd=1 and count>0 → rd_ptr++, count--. s_rd with count==0 is ignored.
- Simultaneous push and pop with 0<count<DEPTH: both happen; count is unchanged.
- Simultaneous push and pop at full: the pop frees a slot, so the push is accepted and there is no overflow, irrespective of OVERWRITE.
- Simultaneous push and pop at empty: the pop is ignored; the push is accepted.
- s_dout next state: if next count>0, it is the head entry after this cycle's updates, with push data forwarded when the FIFO was empty. Otherwise it holds its value, so repeated reads return the last command, as a latch does.
- s_nmi: set on every accepted push. It is also set on a pop that leaves next count>0, so each queued command gets its own interrupt. It is cleared by s_inta. Set wins over a simultaneous clear.
- Reply: s_wr loads m_dout←s_din and sets reply_valid←1. m_rd clears reply_valid; m_dout holds. With s_wr and m_rd together, the new data is loaded and reply_valid stays 1.
- overflow: ovf_clr clears it. An overflow event in the same cycle as ovf_clr wins.

## Timing
- All outputs are registered. No combinational path runs from inputs to outputs.
- m_wr edge N → count, full, s_dout (if the FIFO was empty) and s_nmi all valid after edge N.
- s_rd edge N → next head on s_dout after edge N; the value sampled before the edge is the popped command.
- s_inta edge N → s_nmi low after edge N, unless re-set in the same cycle.
- Reply latency is one cycle in either direction.
- Throughput is one push and one pop per clk_sys.

## Test plan
- After reset, push 0x12, 0x34 on consecutive cycles → count=2, s_dout=0x12, s_nmi=1. Then s_inta → s_nmi=0. Then s_rd → s_dout=0x34, count=1, s_nmi=1.
- DEPTH=4, OVERWRITE=0: push 0x01..0x05 → count=4, full=1, overflow=1; pops return 0x01..0x04. With OVERWRITE=1, the pops return 0x02..0x05.
- CHANGE_ONLY=1: push 0x55, 0x55, 0x66 → count=2, and s_nmi sets twice. With CHANGE_ONLY=0 → count=3.
- Empty FIFO, s_rd pulse → count stays 0 and s_dout keeps the last command. Push 0xA0 together with s_rd → count=1, s_dout=0xA0.
- s_wr 0x7E → reply_valid=1, m_dout=0x7E. Then m_rd together with s_wr 0x7F → reply_valid=1, m_dout=0x7F. Then m_rd → reply_valid=0.
- Assert reset_n=0 mid-sequence, between clock edges, with count=3 and s_nmi=1 → all outputs are 0 immediately, without waiting for an edge.
